// File: rtl/kitchen_timer_ctrl_pkg.sv
// Shared definitions for the MM:SS kitchen timer: FSM state codes and BCD digit limits.
// A helper tells whether a two-digit BCD field reads 00.
package kitchen_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_e;

    localparam logic [3:0] DEC_TENS_MAX = 4'd5;
    localparam logic [3:0] DEC_ONES_MAX = 4'd9;

    function automatic logic bcd_is_zero(input logic [3:0] tens, input logic [3:0] ones);
        return (tens == 4'd0) && (ones == 4'd0);
    endfunction

endpackage

// File: rtl/kitchen_timer_ctrl_bcd60_updown.sv
// Two-digit BCD field (00..59) with wrapping increment and decrement.
// borrow_out is combinational so the next field can decrement on the same edge.
module kitchen_timer_ctrl_bcd60_updown
    import kitchen_timer_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       borrow_out
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        borrow_out = 1'b0;
        if (clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (inc) begin
            if (ones_q == DEC_ONES_MAX) begin
                ones_d = 4'd0;
                tens_d = (tens_q == DEC_TENS_MAX) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (dec) begin
            if (ones_q == 4'd0) begin
                ones_d = DEC_ONES_MAX;
                if (tens_q == 4'd0) begin
                    tens_d     = DEC_TENS_MAX;
                    borrow_out = 1'b1;
                end else begin
                    tens_d = tens_q - 4'd1;
                end
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// MM:SS countdown timer: set/start/pause/clear control, 1 Hz decrement, timed alarm.
// Drives four registered BCD digits for the display scanner.
module kitchen_timer_ctrl
    import kitchen_timer_ctrl_pkg::*;
#(
    parameter int unsigned ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_sec,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_inc_m,
    input  logic       btn_inc_s,
    output logic [3:0] min10,
    output logic [3:0] min1,
    output logic [3:0] sec10,
    output logic [3:0] sec1,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int CW = $clog2(ALARM_SEC + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   acnt_q, acnt_d;
    logic            running_q, running_d;
    logic            alarm_q, alarm_d;

    logic            fld_clr, sec_inc, min_inc, sec_dec, sec_borrow;
    logic            time_zero, time_one;

    kitchen_timer_ctrl_bcd60_updown u_sec (
        .clk        (clk),
        .reset_p    (reset_p),
        .inc        (sec_inc),
        .dec        (sec_dec),
        .clr        (fld_clr),
        .tens       (sec10),
        .ones       (sec1),
        .borrow_out (sec_borrow)
    );

    // Minutes only step down when the seconds field wraps 00 -> 59 on this edge.
    kitchen_timer_ctrl_bcd60_updown u_min (
        .clk        (clk),
        .reset_p    (reset_p),
        .inc        (min_inc),
        .dec        (sec_borrow),
        .clr        (fld_clr),
        .tens       (min10),
        .ones       (min1),
        .borrow_out ()
    );

    assign time_zero = bcd_is_zero(min10, min1) && bcd_is_zero(sec10, sec1);
    assign time_one  = bcd_is_zero(min10, min1) && (sec10 == 4'd0) && (sec1 == 4'd1);

    always_comb begin
        state_d = state_q;
        acnt_d  = acnt_q;
        fld_clr = 1'b0;
        sec_inc = 1'b0;
        min_inc = 1'b0;
        sec_dec = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_clear) begin
                    fld_clr = 1'b1;
                end else if (btn_start) begin
                    if (!time_zero) state_d = ST_RUN;
                end else begin
                    sec_inc = btn_inc_s;
                    min_inc = btn_inc_m;
                end
            end
            ST_RUN: begin
                if (btn_clear) begin
                    fld_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (btn_start) begin
                    state_d = ST_PAUSE;
                end else if (tick_sec) begin
                    sec_dec = 1'b1;
                    if (time_one) state_d = ST_ALARM;
                end
            end
            ST_PAUSE: begin
                if (btn_clear) begin
                    fld_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (btn_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (btn_clear || btn_start) begin
                    fld_clr = btn_clear;
                    acnt_d  = '0;
                    state_d = ST_IDLE;
                end else if (tick_sec) begin
                    if (acnt_q == CW'(ALARM_SEC - 1)) begin
                        acnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        acnt_d = acnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        running_d = (state_d == ST_RUN);
        alarm_d   = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            acnt_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acnt_q    <= acnt_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    assign running = running_q;
    assign alarm   = alarm_q;
    assign state   = state_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Directed bench for kitchen_timer_ctrl: setting, countdown, pause, alarm timeout, clear, reset.
module tb_kitchen_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       tick_sec = 1'b0, btn_start = 1'b0, btn_clear = 1'b0;
    logic       btn_inc_m = 1'b0, btn_inc_s = 1'b0;
    logic [3:0] min10, min1, sec10, sec1;
    logic       running, alarm;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    kitchen_timer_ctrl #(.ALARM_SEC(5)) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .tick_sec  (tick_sec),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_inc_m (btn_inc_m),
        .btn_inc_s (btn_inc_s),
        .min10     (min10),
        .min1      (min1),
        .sec10     (sec10),
        .sec1      (sec1),
        .running   (running),
        .alarm     (alarm),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of strobes at the falling edge, release them 1 ns after the rising edge.
    task automatic step(input logic ts, input logic bs, input logic bc, input logic im, input logic is);
        @(negedge clk);
        tick_sec  = ts;
        btn_start = bs;
        btn_clear = bc;
        btn_inc_m = im;
        btn_inc_s = is;
        @(posedge clk);
        #1;
        tick_sec  = 1'b0;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_inc_m = 1'b0;
        btn_inc_s = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [15:0] tm();
        return {min10, min1, sec10, sec1};
    endfunction

    task automatic chk_all(input string tag, input logic [15:0] t, input logic [1:0] st,
                           input logic run, input logic alm);
        chk({tag, ".time"}, tm(), t);
        chk({tag, ".state"}, {14'd0, state}, {14'd0, st});
        chk({tag, ".running"}, {15'd0, running}, {15'd0, run});
        chk({tag, ".alarm"}, {15'd0, alarm}, {15'd0, alm});
    endtask

    initial begin
        // 1: reset, then set 02:03
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_p = 1'b0;
        repeat (3) step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 1, 0);
        chk_all("set0203", 16'h0203, 2'd0, 1'b0, 1'b0);

        // 2: 00:02 countdown into alarm, alarm lasts 5 ticks
        step(0, 0, 1, 0, 0);
        chk("clear_idle", tm(), 16'h0000);
        repeat (2) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk_all("start2", 16'h0002, 2'd1, 1'b1, 1'b0);
        step(1, 0, 0, 0, 0);
        chk_all("tick1", 16'h0001, 2'd1, 1'b1, 1'b0);
        step(1, 0, 0, 0, 0);
        chk_all("expire", 16'h0000, 2'd3, 1'b0, 1'b1);
        repeat (4) step(1, 0, 0, 0, 0);
        chk_all("alarm4", 16'h0000, 2'd3, 1'b0, 1'b1);
        step(1, 0, 0, 0, 0);
        chk_all("alarm_end", 16'h0000, 2'd0, 1'b0, 1'b0);

        // 3: minute borrow, inc ignored in RUN, ten-minute borrow
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_all("borrow_m", 16'h0059, 2'd1, 1'b1, 1'b0);
        step(0, 0, 0, 1, 1);
        chk("run_inc_ign", tm(), 16'h0059);
        step(0, 0, 1, 0, 0);
        chk_all("run_clear", 16'h0000, 2'd0, 1'b0, 1'b0);
        repeat (10) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("borrow_m10", tm(), 16'h0959);
        step(0, 0, 1, 0, 0);

        // 4: pause with simultaneous tick, frozen time, resume
        repeat (10) step(0, 0, 0, 0, 1);
        chk("set0010", tm(), 16'h0010);
        step(0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0);
        chk("run0007", tm(), 16'h0007);
        step(1, 1, 0, 0, 0);
        chk_all("pause", 16'h0007, 2'd2, 1'b0, 1'b0);
        repeat (3) step(1, 0, 0, 1, 1);
        chk_all("frozen", 16'h0007, 2'd2, 1'b0, 1'b0);
        step(0, 1, 0, 0, 0);
        chk_all("resume", 16'h0007, 2'd1, 1'b1, 1'b0);
        step(1, 0, 0, 0, 0);
        chk("run0006", tm(), 16'h0006);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk_all("pause_clear", 16'h0000, 2'd0, 1'b0, 1'b0);

        // 5: start at 00:00 ignored; seconds and minutes wrap without carry
        step(0, 1, 0, 0, 0);
        chk_all("start_zero", 16'h0000, 2'd0, 1'b0, 1'b0);
        repeat (59) step(0, 0, 0, 0, 1);
        chk("sec59", tm(), 16'h0059);
        step(0, 0, 0, 0, 1);
        chk("sec_wrap", tm(), 16'h0000);
        repeat (59) step(0, 0, 0, 1, 0);
        chk("min59", tm(), 16'h5900);
        step(0, 0, 0, 1, 0);
        chk("min_wrap", tm(), 16'h0000);
        step(0, 0, 0, 1, 1);
        chk("inc_both", tm(), 16'h0101);
        step(0, 0, 1, 0, 0);

        // 6: alarm abort, counter restart, async reset mid-RUN
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_all("alarm_in", 16'h0000, 2'd3, 1'b0, 1'b1);
        step(0, 1, 1, 0, 0);
        chk_all("alarm_abort", 16'h0000, 2'd0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk_all("alarm_start", 16'h0000, 2'd0, 1'b0, 1'b0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (4) step(1, 0, 0, 0, 0);
        chk("acnt_reset", {15'd0, alarm}, 16'd1);
        step(1, 0, 0, 0, 0);
        chk("acnt_end", {15'd0, alarm}, 16'd0);
        repeat (3) step(0, 0, 0, 1, 0);
        repeat (27) step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk_all("run0327", 16'h0327, 2'd1, 1'b1, 1'b0);
        @(negedge clk);
        reset_p = 1'b1;
        #1;
        chk_all("async_rst", 16'h0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_p = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
